// File: rtl/fmap_stream_pkg.sv
// Shared types and sizing helpers for the feature-map stream transmitter.
package fmap_stream_pkg;

  // Frame sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_VSYNC = 3'd1,
    ST_HSYNC = 3'd2,
    ST_HWAIT = 3'd3,
    ST_DATA  = 3'd4,
    ST_PAD   = 3'd5,
    ST_DRAIN = 3'd6
  } state_t;

  // Stream flags carried through the read-latency alignment pipeline
  typedef struct packed {
    logic vsync;
    logic hsync;
    logic valid;
  } flags_t;

  // Counter width for a counter that must hold 0..n-1 (never narrower than 1 bit)
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // The wait counter also times the 2-cycle drain, so it always holds at least 0..1
  function automatic int wait_w(input int vslen, input int hswait, input int padwait);
    return cnt_w(max3(vslen, hswait, padwait) + 1);
  endfunction

  // Cycles from start accept to the o_done pulse
  function automatic int frame_len(input int vslen, input int size, input int hswait,
                                   input int channel, input int padwait);
    return vslen + size * (1 + hswait + size * channel + padwait) + 2;
  endfunction

  localparam int DEF_WIDTH   = 27;
  localparam int DEF_SIZE    = 56;
  localparam int DEF_CHANNEL = 64;
  localparam int DEF_PADWAIT = 21;
  localparam int DEF_HSWAIT  = 2;
  localparam int DEF_VSLEN   = 4;
  localparam int DEF_ADDR_W  = 18;

  localparam int DEF_BEAT_W    = cnt_w(DEF_SIZE * DEF_CHANNEL);
  localparam int DEF_ROW_W     = cnt_w(DEF_SIZE);
  localparam int DEF_WAIT_W    = wait_w(DEF_VSLEN, DEF_HSWAIT, DEF_PADWAIT);
  localparam int DEF_FRAME_LEN = frame_len(DEF_VSLEN, DEF_SIZE, DEF_HSWAIT,
                                           DEF_CHANNEL, DEF_PADWAIT);

endpackage

// File: rtl/stream_align_dly.sv
// Two-stage delay of the stream flags, matching the buffer read latency plus
// the output register. Stage 1 is exposed so the top can mask arriving data.
module stream_align_dly
  import fmap_stream_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  flags_t d,
  output flags_t q_p1,
  output flags_t q_p2
);

  flags_t flags_p1;
  flags_t flags_p2;

  // Shift flags through both stages; async clear drops the stream at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_p1 <= '0;
      flags_p2 <= '0;
    end else begin
      flags_p1 <= d;
      flags_p2 <= flags_p1;
    end
  end

  assign q_p1 = flags_p1;
  assign q_p2 = flags_p2;

endmodule

// File: rtl/fmap_stream_tx.sv
// Feature-map stream transmitter: walks a SIZE x SIZE x CHANNEL map out of a
// linear buffer (1-cycle read latency) and emits vsync/hsync/valid/tdata with
// the idle gaps the downstream padding pipelines rely on.
module fmap_stream_tx
  import fmap_stream_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SIZE    = DEF_SIZE,
  parameter int CHANNEL = DEF_CHANNEL,
  parameter int PADWAIT = DEF_PADWAIT,
  parameter int HSWAIT  = DEF_HSWAIT,
  parameter int VSLEN   = DEF_VSLEN,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input  logic              i_sclk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  output logic              o_rden,
  output logic [ADDR_W-1:0] o_rdaddr,
  input  logic [WIDTH-1:0]  i_rddata,
  output logic              o_vsync,
  output logic              o_hsync,
  output logic              o_valid,
  output logic [WIDTH-1:0]  o_tdata,
  output logic              o_busy,
  output logic              o_done
);

  localparam int BEAT_W = cnt_w(SIZE * CHANNEL);
  localparam int ROW_W  = cnt_w(SIZE);
  localparam int WAIT_W = wait_w(VSLEN, HSWAIT, PADWAIT);

  // Terminal counts; the HSWAIT/PADWAIT ones are unused when that wait is zero
  localparam logic [BEAT_W-1:0] BEAT_LAST  = BEAT_W'(SIZE * CHANNEL - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(SIZE - 1);
  localparam logic [WAIT_W-1:0] VS_LAST    = WAIT_W'(VSLEN - 1);
  localparam logic [WAIT_W-1:0] HS_LAST    = WAIT_W'(HSWAIT - 1);
  localparam logic [WAIT_W-1:0] PAD_LAST   = WAIT_W'(PADWAIT - 1);
  localparam logic [WAIT_W-1:0] DRAIN_LAST = WAIT_W'(1);

  state_t              state;
  state_t              state_nxt;
  logic                done;
  logic [BEAT_W-1:0]   beat_cnt;
  logic [ROW_W-1:0]    row_cnt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [ADDR_W-1:0]   addr;
  logic                row_last;

  flags_t              flags_p0;
  flags_t              flags_p1;
  flags_t              flags_p2;
  logic [WIDTH-1:0]    tdata_p2;

  assign row_last = (row_cnt == ROW_LAST);

  // State register
  always_ff @(posedge i_sclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; o_done is raised on the final drain cycle
  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (i_start) begin
          state_nxt = ST_VSYNC;
        end
      end
      ST_VSYNC: begin
        if (wait_cnt == VS_LAST) begin
          state_nxt = ST_HSYNC;
        end
      end
      ST_HSYNC: begin
        state_nxt = (HSWAIT == 0) ? ST_DATA : ST_HWAIT;
      end
      ST_HWAIT: begin
        if (wait_cnt == HS_LAST) begin
          state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (beat_cnt == BEAT_LAST) begin
          if (PADWAIT != 0) begin
            state_nxt = ST_PAD;
          end else begin
            state_nxt = row_last ? ST_DRAIN : ST_HSYNC;
          end
        end
      end
      ST_PAD: begin
        if (wait_cnt == PAD_LAST) begin
          state_nxt = row_last ? ST_DRAIN : ST_HSYNC;
        end
      end
      ST_DRAIN: begin
        if (wait_cnt == DRAIN_LAST) begin
          state_nxt = ST_IDLE;
          done      = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Wait, beat and row counters plus the buffer address counter
  always_ff @(posedge i_sclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wait_cnt <= '0;
      beat_cnt <= '0;
      row_cnt  <= '0;
      addr     <= '0;
    end else begin
      // wait counter restarts on every state change so each timed state counts from 0
      if (state_nxt != state) begin
        wait_cnt <= '0;
      end else if (state != ST_IDLE && state != ST_DATA) begin
        wait_cnt <= wait_cnt + 1'b1;
      end

      if (state == ST_DATA && state_nxt == ST_DATA) begin
        beat_cnt <= beat_cnt + 1'b1;
      end else begin
        beat_cnt <= '0;
      end

      // a row completes whenever HSYNC is re-entered from anything but VSYNC
      if (state == ST_IDLE) begin
        row_cnt <= '0;
      end else if (state_nxt == ST_HSYNC && state != ST_VSYNC) begin
        row_cnt <= row_cnt + 1'b1;
      end

      // address wraps modulo 2^ADDR_W by construction
      if (state == ST_IDLE && i_start) begin
        addr <= i_base_addr;
      end else if (state == ST_DATA) begin
        addr <= addr + 1'b1;
      end
    end
  end

  assign o_rden   = (state == ST_DATA);
  assign o_rdaddr = addr;
  assign o_busy   = (state != ST_IDLE);
  assign o_done   = done;

  // p0: flags decoded from the FSM, issued alongside the buffer read
  assign flags_p0.vsync = (state == ST_VSYNC);
  assign flags_p0.hsync = (state == ST_HSYNC);
  assign flags_p0.valid = (state == ST_DATA);

  stream_align_dly u_align (
    .clk   (i_sclk),
    .rst_n (i_rst_n),
    .d     (flags_p0),
    .q_p1  (flags_p1),
    .q_p2  (flags_p2)
  );

  // p2: read data arrives with the p1 flags; zero it outside valid beats
  always_ff @(posedge i_sclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tdata_p2 <= '0;
    end else begin
      tdata_p2 <= flags_p1.valid ? i_rddata : '0;
    end
  end

  assign o_vsync = flags_p2.vsync;
  assign o_hsync = flags_p2.hsync;
  assign o_valid = flags_p2.valid;
  assign o_tdata = tdata_p2;

endmodule

// File: tb/tb_fmap_stream_tx.sv
// Bench for fmap_stream_tx: two small instances (with and without idle gaps)
// checked cycle by cycle against a positional model of the frame.
module tb_fmap_stream_tx;
  import fmap_stream_pkg::*;

  localparam int W  = 27;
  localparam int AW = 18;
  localparam int SZ = 4;
  localparam int CH = 2;
  localparam int VS = 4;
  localparam int SC = SZ * CH;
  localparam int BEATS = SZ * SZ * CH;

  // {vsync, hsync, valid, tdata, rden, rdaddr, busy, done}
  typedef logic [50:0] obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          start_a, start_b;
  logic [AW-1:0] base_a, base_b;
  logic [W-1:0]  rdd_a, rdd_b;
  logic [W-1:0]  salt;

  logic          rden_a, vs_a, hs_a, va_a, busy_a, done_a;
  logic [AW-1:0] rdaddr_a;
  logic [W-1:0]  td_a;
  logic          rden_b, vs_b, hs_b, va_b, busy_b, done_b;
  logic [AW-1:0] rdaddr_b;
  logic [W-1:0]  td_b;

  obs_t obs_a, obs_b;
  assign obs_a = {vs_a, hs_a, va_a, td_a, rden_a, rdaddr_a, busy_a, done_a};
  assign obs_b = {vs_b, hs_b, va_b, td_b, rden_b, rdaddr_b, busy_b, done_b};

  fmap_stream_tx #(.WIDTH(W), .SIZE(SZ), .CHANNEL(CH), .PADWAIT(3), .HSWAIT(2),
                   .VSLEN(VS), .ADDR_W(AW)) dut_a (
    .i_sclk(clk), .i_rst_n(rst_n), .i_start(start_a), .i_base_addr(base_a),
    .o_rden(rden_a), .o_rdaddr(rdaddr_a), .i_rddata(rdd_a),
    .o_vsync(vs_a), .o_hsync(hs_a), .o_valid(va_a), .o_tdata(td_a),
    .o_busy(busy_a), .o_done(done_a)
  );

  fmap_stream_tx #(.WIDTH(W), .SIZE(SZ), .CHANNEL(CH), .PADWAIT(0), .HSWAIT(0),
                   .VSLEN(VS), .ADDR_W(AW)) dut_b (
    .i_sclk(clk), .i_rst_n(rst_n), .i_start(start_b), .i_base_addr(base_b),
    .o_rden(rden_b), .o_rdaddr(rdaddr_b), .i_rddata(rdd_b),
    .o_vsync(vs_b), .o_hsync(hs_b), .o_valid(va_b), .o_tdata(td_b),
    .o_busy(busy_b), .o_done(done_b)
  );

  // Buffer content: word at address a is a ^ salt (salt = 0 gives word n = n)
  function automatic logic [W-1:0] word(input logic [AW-1:0] a, input logic [W-1:0] s);
    return {{(W-AW){1'b0}}, a} ^ s;
  endfunction

  // Buffer models with 1-cycle latency; garbage when not read, to expose masking
  always @(posedge clk) begin
    rdd_a <= rden_a ? word(rdaddr_a, salt) : W'($urandom);
    rdd_b <= rden_b ? word(rdaddr_b, salt) : W'($urandom);
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic obs_t cur(input int sel);
    return (sel != 0) ? obs_b : obs_a;
  endfunction

  task automatic set_start(input int sel, input logic v);
    if (sel != 0) start_b = v; else start_a = v;
  endtask

  task automatic set_base(input int sel, input logic [AW-1:0] b);
    if (sel != 0) base_b = b; else base_a = b;
  endtask

  // Present base and raise start in the current (idle) cycle
  task automatic kick(input int sel, input logic [AW-1:0] b);
    set_base(sel, b);
    set_start(sel, 1'b1);
  endtask

  // Follow one frame from the cycle after start accept through one idle cycle.
  // hold keeps start high (back-to-back); mid pulses start while busy;
  // abort_at applies reset at that cycle; next_base is presented after accept.
  task automatic run_frame(input string tag, input int sel, input logic [AW-1:0] base,
                           input logic hold, input int mid, input int abort_at,
                           input logic [AW-1:0] next_base);
    int hsw, pdw, rlen, n, c0, nvs, nhs, nva, nd;
    logic fvs[100];
    logic fhs[100];
    logic frd[100];
    logic [AW-1:0] fad[100];
    obs_t got, exp;
    hsw = (sel != 0) ? 0 : 2;
    pdw = (sel != 0) ? 0 : 3;
    rlen = 1 + hsw + SC + pdw;
    n = frame_len(VS, SZ, hsw, CH, pdw);
    for (int i = 0; i < 100; i++) begin
      fvs[i] = 1'b0; fhs[i] = 1'b0; frd[i] = 1'b0; fad[i] = '0;
    end
    for (int i = 1; i <= VS; i++) fvs[i] = 1'b1;
    for (int r = 0; r < SZ; r++) begin
      c0 = VS + 1 + r * rlen;
      fhs[c0] = 1'b1;
      for (int b = 0; b < SC; b++) begin
        frd[c0 + 1 + hsw + b] = 1'b1;
        fad[c0 + 1 + hsw + b] = AW'(base + AW'(r * SC + b));
      end
    end
    nvs = 0; nhs = 0; nva = 0;
    for (int c = 1; c <= n + 1; c++) begin
      @(negedge clk);
      if (c == abort_at) begin
        rst_n = 1'b0;
        #1;
        check({tag, " rst_now_a"}, obs_a, '0);
        check({tag, " rst_now_b"}, obs_b, '0);
        start_a = 1'b0;
        start_b = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int k = 0; k < 80; k++) begin
          @(negedge clk);
          nd += int'(cur(sel)[0]);
        end
        check({tag, " no_done_after_rst"}, nd, 0);
        return;
      end
      got = cur(sel);
      if (!got[20]) got[19:2] = '0;
      exp = '0;
      if (c >= 2) begin
        exp[50] = fvs[c-2];
        exp[49] = fhs[c-2];
        exp[48] = frd[c-2];
        exp[47:21] = frd[c-2] ? word(fad[c-2], salt) : '0;
      end
      exp[20] = frd[c];
      exp[19:2] = frd[c] ? fad[c] : '0;
      exp[1] = (c <= n);
      exp[0] = (c == n);
      check($sformatf("%s c%0d", tag, c), got, exp);
      nvs += int'(got[50]);
      nhs += int'(got[49]);
      nva += int'(got[48]);
      if (c == 1) begin
        if (!hold) set_start(sel, 1'b0);
        set_base(sel, next_base);
      end
      if (mid != 0 && c == mid) set_start(sel, 1'b1);
      if (mid != 0 && c == mid + 1 && !hold) set_start(sel, 1'b0);
    end
    check({tag, " vsync_cycles"}, nvs, VS);
    check({tag, " hsync_pulses"}, nhs, SZ);
    check({tag, " valid_beats"}, nva, BEATS);
  endtask

  initial begin
    logic [AW-1:0] b, b2, b3;
    rst_n   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    base_a  = '0;
    base_b  = '0;
    salt    = '0;
    repeat (3) @(negedge clk);
    check("reset_a", obs_a, '0);
    check("reset_b", obs_b, '0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Word n = n from base 0
    kick(0, '0);
    run_frame("a_base0", 0, '0, 1'b0, 0, 0, AW'($urandom));
    repeat (2) @(negedge clk);

    // Random base and data, with a start pulse while busy
    b = AW'($urandom);
    salt = W'($urandom);
    kick(0, b);
    run_frame("a_rand", 0, b, 1'b0, 20, 0, AW'($urandom));
    repeat (3) @(negedge clk);

    // Address wrap across 2^18-1
    b = AW'((1 << AW) - 5);
    kick(0, b);
    run_frame("a_wrap", 0, b, 1'b0, 0, 0, '0);
    repeat (2) @(negedge clk);

    // No idle gaps
    salt = '0;
    kick(1, '0);
    run_frame("b_base0", 1, '0, 1'b0, 0, 0, '0);
    b = AW'($urandom);
    salt = W'($urandom);
    kick(1, b);
    run_frame("b_rand", 1, b, 1'b0, 7, 0, AW'($urandom));
    repeat (2) @(negedge clk);

    // Reset during row 2, then a fresh frame
    b = AW'($urandom);
    kick(0, b);
    run_frame("a_abort", 0, b, 1'b0, 0, VS + 1 + 2 * 14 + 5, '0);
    b = AW'($urandom);
    salt = W'($urandom);
    kick(0, b);
    run_frame("a_after_rst", 0, b, 1'b0, 0, 0, '0);
    repeat (2) @(negedge clk);

    // Start held high: frames repeat with one idle cycle between
    b  = AW'($urandom);
    b2 = AW'($urandom);
    b3 = AW'($urandom);
    kick(0, b);
    run_frame("a_hold1", 0, b, 1'b1, 10, 0, b2);
    run_frame("a_hold2", 0, b2, 1'b1, 0, 0, b3);
    run_frame("a_hold3", 0, b3, 1'b0, 0, 0, '0);
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fmap_stream_tx.md
Name: fmap_stream_tx

Overview:
- Transmit end of the feature-map stream protocol consumed by the row-reshape / padding front end of each conv group.
- Reads one SIZE x SIZE x CHANNEL feature map from a linear buffer with a fixed 1-cycle read latency.
- Emits it as a vsync / hsync / valid / tdata stream, with the idle gaps the downstream padding pipelines require.
- Sits between the layer output buffer and the next layer's input reshaper.

Parameters:
- WIDTH, 27, data word width.
- SIZE, 56, feature-map rows and columns.
- CHANNEL, 64, channels per pixel; channel is the minor index within a row.
- PADWAIT, 21, idle cycles after each row's last valid beat.
- HSWAIT, 2, idle cycles between the hsync pulse and a row's first valid beat.
- VSLEN, 4, cycles vsync is held high before the first row.
- ADDR_W, 18, buffer address width; must satisfy 2^ADDR_W >= SIZE*SIZE*CHANNEL.

Ports:
- i_sclk, in, 1, clock.
- i_rst_n, in, 1, asynchronous active-low reset.
- i_start, in, 1, frame start request, sampled in IDLE only.
- i_base_addr, in, ADDR_W, buffer address of the first word; latched on an accepted start.
- o_rden, out, 1, buffer read enable.
- o_rdaddr, out, ADDR_W, buffer read address.
- i_rddata, in, WIDTH, buffer read data; valid exactly 1 cycle after o_rden.
- o_vsync, out, 1, frame sync (active high; downstream FIFOs use it as reset).
- o_hsync, out, 1, one-cycle row-start pulse.
- o_valid, out, 1, data beat valid.
- o_tdata, out, WIDTH, data; forced to 0 when o_valid = 0.
- o_busy, out, 1, frame in progress, pipeline drain included.
- o_done, out, 1, one-cycle pulse after the last output cycle of a frame.

Behaviour:
- Reset (i_rst_n = 0, asynchronous): FSM goes to IDLE; all counters and pipeline registers clear; every output is 0. Deassertion is synchronous to i_sclk.
- FSM states: IDLE, VSYNC, HSYNC, HWAIT, DATA, PAD, DRAIN.
- IDLE -> VSYNC when i_start = 1; latch i_base_addr into the address counter. i_start in any other state is ignored.
- VSYNC: VSLEN cycles, then HSYNC.
- HSYNC: 1 cycle, then HWAIT; if HSWAIT = 0, go straight to DATA.
- HWAIT: HSWAIT cycles, then DATA.
- DATA: SIZE*CHANNEL cycles. Each cycle asserts o_rden with the current address, then increments the address. Then PAD.
- PAD: PADWAIT cycles. Then HSYNC if rows remain, else DRAIN. If PADWAIT = 0, the transition happens directly from DATA.
- DRAIN: 2 cycles, then IDLE. o_done pulses in the last DRAIN cycle.
- o_rden and o_rdaddr are combinational from the FSM state and address counter: rden = (state == DATA).
- All other stream outputs are registered and delayed 2 cycles from the FSM stage:
  - stage 1 captures the vsync/hsync/valid flags while the buffer read is in flight;
  - stage 2 registers the flags and o_tdata = valid ? i_rddata : 0.
- Consequence: the first o_valid appears 2 cycles after the first o_rden.
- o_vsync is high for exactly VSLEN cycles per frame. o_hsync is high for exactly SIZE single-cycle pulses per frame.
- Valid beats per frame: exactly SIZE*SIZE*CHANNEL, contiguous within a row, never interrupted.
- Frame length from start accept to o_done: VSLEN + SIZE*(1 + HSWAIT + SIZE*CHANNEL + PADWAIT) + 2 cycles.
- o_busy is high from the cycle after start accept through the o_done cycle.
- Back-to-back frames: i_start asserted in the cycle after o_done is accepted, giving one IDLE cycle between frames.
- Address arithmetic is ADDR_W bits unsigned and wraps modulo 2^ADDR_W. Wrap within a frame is legal; no error is flagged.
- Counters: beat counter sized clog2(SIZE*CHANNEL), row counter clog2(SIZE), wait counter clog2(max(VSLEN, HSWAIT, PADWAIT) + 1).
- Reset mid-frame: outputs drop to 0 at once; no o_done is issued; the next i_start begins a fresh frame.

Decomposition:
- Package fmap_stream_pkg: FSM state enum; clog2-based width constants for the beat, row and wait counters; the frame-length constant, which the bench also uses.
- One sub-module, stream_align_dly: a 2-stage register delay for the {vsync, hsync, valid} flags with async active-low clear. Data masking stays in the top.

Test Plan:
- Case 1, SIZE=4, CHANNEL=2, PADWAIT=3, HSWAIT=2, VSLEN=4, base=0, buffer word n = n: start -> 32 valid beats carrying 0..31 in order; 4 hsync pulses; o_vsync high 4 cycles; o_done exactly 4+4*(1+2+8+3)+2 = 62 cycles after start accept.
- Same config, timing: each hsync is followed by exactly 2 zero cycles, then 8 valid beats, then 3 zero cycles; o_tdata = 0 on every non-valid cycle.
- base = 2^18-5 with a 32-word map: o_rdaddr wraps to 0 after 2^18-1; data order is preserved.
- PADWAIT=0, HSWAIT=0: rows are spaced only by the hsync cycle; beat count is still 32; o_done timing matches the formula (4+4*9+2 = 42).
- i_rst_n pulsed low during row 2: all outputs 0 within the same cycle; no o_done; a new start then produces a complete, correct frame.
- i_start held high continuously: frames repeat with exactly one IDLE cycle between o_done and the next vsync-stage start; a start pulse during busy is ignored.
